// File: rtl/ram_stream_reader.sv
// Fetches a block of consecutive words from a 1-cycle-latency synchronous RAM
// and streams them out on a valid/ready interface through a 2-entry skid FIFO.
module ram_stream_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]      ram_rd_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [1:0]            dbg_state
);

    // Stream handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both high; out_valid/out_data hold steady until that edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  recv_cnt_q, recv_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]      mem_q [2];
    logic [WIDTH-1:0]      mem_d [2];

    logic       pop;
    logic       push;
    logic       rd_en;
    logic [2:0] occ;

    always_comb begin
        pop   = (fifo_cnt_q != 2'd0) && out_ready;
        push  = inflight_q;
        // Occupancy after this edge if no new read were issued; a read is only
        // issued when its data is guaranteed a free FIFO slot on arrival.
        occ   = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        rd_en = (state_q == S_RUN) && (issue_cnt_q != '0) && (occ < 3'd2);

        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        inflight_d  = rd_en;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        fifo_cnt_d  = fifo_cnt_q + 2'(push) - 2'(pop);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d      = base_addr;
                        issue_cnt_d = length;
                        recv_cnt_d  = length;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    addr_d      = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    recv_cnt_d = recv_cnt_q - LEN_WIDTH'(1);
                    if (recv_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = ram_rd_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
        end
    end

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = addr_q;
    assign out_valid   = (fifo_cnt_q != 2'd0);
    assign out_data    = mem_q[rd_ptr_q];
    assign out_last    = out_valid && (recv_cnt_q == LEN_WIDTH'(1));
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state   = state_q;

endmodule
